// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_pkg;

    localparam int         ADDR_W_DEF = 8;
    localparam int         INST_W_DEF = 9;
    localparam logic [8:0] HALT_INST  = 9'h1FF;

    typedef logic [ADDR_W_DEF-1:0] addr_t;
    typedef logic [INST_W_DEF-1:0] inst_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_pc.sv
// Program counter register: load wins over increment, otherwise hold.
module fetch_pc #(
    parameter int                ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] START_PC = 8'h00
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load_i,
    input  logic [ADDR_W-1:0] load_addr_i,
    input  logic              inc_i,
    output logic [ADDR_W-1:0] pc_o
);

    logic [ADDR_W-1:0] pc_q, pc_d;

    always_comb begin
        pc_d = pc_q;
        if (load_i)
            pc_d = load_addr_i;
        else if (inc_i)
            pc_d = pc_q + 1'b1;  // wraps naturally at 2^ADDR_W
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            pc_q <= START_PC;
        else
            pc_q <= pc_d;
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/inst_fetch.sv
// Instruction-fetch front end: drives the ROM address from the PC, captures the
// returned instruction into a one-entry register and hands it to decode.
module inst_fetch
    import fetch_pkg::*;
#(
    parameter int                ADDR_W    = 8,
    parameter int                INST_W    = 9,
    parameter logic [INST_W-1:0] HALT_INST = 9'h1FF,
    parameter logic [ADDR_W-1:0] START_PC  = 8'h00
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Start,
    input  logic [ADDR_W-1:0] StartAddr,
    output logic [ADDR_W-1:0] RomAddress,
    input  logic [INST_W-1:0] RomInst,
    output logic [INST_W-1:0] InstOut,
    output logic [ADDR_W-1:0] InstPC,
    output logic              InstValid,
    input  logic              DecReady,
    input  logic              BranchTaken,
    input  logic [ADDR_W-1:0] BranchTarget,
    output logic              Done
);

    fetch_state_t      state_q, state_d;
    logic [INST_W-1:0] inst_q, inst_d;
    logic [ADDR_W-1:0] inst_pc_q, inst_pc_d;
    logic              valid_q, valid_d;
    logic              done_q, done_d;
    logic              halt_pend_q, halt_pend_d;

    logic              pc_load, pc_inc;
    logic [ADDR_W-1:0] pc_load_addr, pc;
    logic              fire, drain;

    fetch_pc #(
        .ADDR_W   (ADDR_W),
        .START_PC (START_PC)
    ) u_pc (
        .clk_i       (Clk),
        .rst_i       (Reset),
        .load_i      (pc_load),
        .load_addr_i (pc_load_addr),
        .inc_i       (pc_inc),
        .pc_o        (pc)
    );

    // A fetch needs an empty register or one decode is taking this cycle.
    assign fire  = !halt_pend_q && (!valid_q || DecReady);
    assign drain = halt_pend_q && valid_q && DecReady && (inst_q == HALT_INST);

    always_comb begin
        state_d      = state_q;
        inst_d       = inst_q;
        inst_pc_d    = inst_pc_q;
        valid_d      = valid_q;
        done_d       = done_q;
        halt_pend_d  = halt_pend_q;
        pc_load      = 1'b0;
        pc_load_addr = StartAddr;
        pc_inc       = 1'b0;

        case (state_q)
            IDLE: begin
                if (Start) begin
                    pc_load = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (BranchTaken) begin
                    pc_load      = 1'b1;
                    pc_load_addr = BranchTarget;
                    valid_d      = 1'b0;
                    halt_pend_d  = 1'b0;
                end else if (fire) begin
                    inst_d    = RomInst;
                    inst_pc_d = pc;
                    valid_d   = 1'b1;
                    // Park the PC on the halt so nothing past it is fetched.
                    if (RomInst == HALT_INST)
                        halt_pend_d = 1'b1;
                    else
                        pc_inc = 1'b1;
                end else if (drain) begin
                    valid_d = 1'b0;
                    done_d  = 1'b1;
                    state_d = HALTED;
                end
            end
            HALTED: begin
                if (Start) begin
                    pc_load     = 1'b1;
                    done_d      = 1'b0;
                    halt_pend_d = 1'b0;
                    state_d     = RUN;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q     <= IDLE;
            inst_q      <= '0;
            inst_pc_q   <= '0;
            valid_q     <= 1'b0;
            done_q      <= 1'b0;
            halt_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            inst_q      <= inst_d;
            inst_pc_q   <= inst_pc_d;
            valid_q     <= valid_d;
            done_q      <= done_d;
            halt_pend_q <= halt_pend_d;
        end
    end

    assign RomAddress = pc;
    assign InstOut    = inst_q;
    assign InstPC     = inst_pc_q;
    assign InstValid  = valid_q;
    assign Done       = done_q;

    a_done_no_valid: assert property (@(posedge Clk) disable iff (Reset) Done |-> !InstValid);
    a_idle_no_valid: assert property (@(posedge Clk) disable iff (Reset) (state_q == IDLE) |-> !InstValid);

endmodule

// File: tb/tb_inst_fetch.sv
// Directed + randomized bench for inst_fetch against a behavioural fetch model.
module tb_inst_fetch;

    logic       Clk = 1'b0;
    logic       Reset, Start, DecReady, BranchTaken;
    logic [7:0] StartAddr, BranchTarget, RomAddress, InstPC;
    logic [8:0] RomInst, InstOut;
    logic       InstValid, Done;

    logic [8:0] rom [256];
    int n_pass  = 0;
    int n_total = 0;

    // Reference model: program counter, one-entry fetch slot, run/halt flags.
    bit m_run, m_done, m_valid, m_hp;
    int m_pc, m_out, m_opc;

    always #5 Clk = ~Clk;

    assign RomInst = rom[RomAddress];

    inst_fetch dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .Start        (Start),
        .StartAddr    (StartAddr),
        .RomAddress   (RomAddress),
        .RomInst      (RomInst),
        .InstOut      (InstOut),
        .InstPC       (InstPC),
        .InstValid    (InstValid),
        .DecReady     (DecReady),
        .BranchTaken  (BranchTaken),
        .BranchTarget (BranchTarget),
        .Done         (Done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic check_all(input string tag);
        check({tag, ".addr"},  RomAddress, m_pc);
        check({tag, ".valid"}, InstValid,  m_valid);
        check({tag, ".done"},  Done,       m_done);
        if (m_valid) begin
            check({tag, ".inst"}, InstOut, m_out);
            check({tag, ".ipc"},  InstPC,  m_opc);
        end
    endtask

    task automatic model_reset();
        m_run = 0; m_done = 0; m_valid = 0; m_hp = 0;
        m_pc = 0; m_out = 0; m_opc = 0;
    endtask

    // One clock: advance the model from the inputs seen at this edge, then compare.
    task automatic tick(input string tag);
        bit nr, nd, nv, nh;
        int npc, nout, nopc, ri;
        nr = m_run; nd = m_done; nv = m_valid; nh = m_hp;
        npc = m_pc; nout = m_out; nopc = m_opc;
        if (m_done) begin
            if (Start) begin npc = StartAddr; nd = 0; nh = 0; nr = 1; end
        end else if (!m_run) begin
            if (Start) begin npc = StartAddr; nr = 1; end
        end else if (BranchTaken) begin
            npc = BranchTarget; nv = 0; nh = 0;
        end else if (!m_hp && (!m_valid || DecReady)) begin
            ri = rom[m_pc];
            nout = ri; nopc = m_pc; nv = 1;
            if (ri == 9'h1FF) nh = 1;
            else npc = (m_pc + 1) % 256;
        end else if (m_hp && m_valid && DecReady && m_out == 9'h1FF) begin
            nv = 0; nr = 0; nd = 1;
        end
        @(posedge Clk);
        #1;
        m_run = nr; m_done = nd; m_valid = nv; m_hp = nh;
        m_pc = npc; m_out = nout; m_opc = nopc;
        check_all(tag);
    endtask

    initial begin
        logic [8:0] exp1 [4];
        exp1 = '{9'h001, 9'h002, 9'h003, 9'h1FF};
        for (int i = 0; i < 256; i++) rom[i] = {1'b0, 8'(i)};
        for (int i = 0; i < 4; i++) rom[i] = exp1[i];
        for (int i = 0; i < 4; i++) rom[8'h10 + i] = 9'h050 + 9'(i);
        rom[8'h14] = 9'h1FF;

        Reset = 1; Start = 0; StartAddr = 0; DecReady = 0;
        BranchTaken = 0; BranchTarget = 0;
        model_reset();
        #2;
        check("rst.valid", InstValid, 0);
        check("rst.done",  Done, 0);
        check("rst.addr",  RomAddress, 8'h00);
        check("rst.inst",  InstOut, 9'h000);
        check("rst.ipc",   InstPC, 8'h00);
        #10 Reset = 0;

        // Straight run to halt
        Start = 1; StartAddr = 8'h00; DecReady = 1;
        tick("t1.start");
        Start = 0;
        check("t1.latency", InstValid, 0);
        for (int k = 0; k < 4; k++) begin
            tick("t1.run");
            check("t1.inst", InstOut, exp1[k]);
            check("t1.ipc",  InstPC, 32'(k));
        end
        tick("t1.drain");
        check("t1.done", Done, 1);

        // BranchTaken ignored while halted, then restart clears Done
        BranchTaken = 1; BranchTarget = 8'h40;
        tick("hlt.br");
        check("hlt.addr_hold", RomAddress, 8'h03);
        BranchTaken = 0; Start = 1; StartAddr = 8'h00;
        tick("hlt.restart");
        Start = 0;
        check("hlt.done_clr", Done, 0);

        // Stall holding 002
        tick("t2.f1");
        tick("t2.f2");
        DecReady = 0;
        for (int k = 0; k < 3; k++) begin
            tick("t2.stall");
            check("t2.inst", InstOut, 9'h002);
            check("t2.ipc",  InstPC, 8'h01);
            check("t2.pc",   RomAddress, 8'h02);
        end
        DecReady = 1;
        tick("t2.resume");
        check("t2.inst3", InstOut, 9'h003);

        // Branch squashes a pending halt
        tick("t5.halt");
        check("t5.halt_inst", InstOut, 9'h1FF);
        BranchTaken = 1; BranchTarget = 8'h10;
        tick("t5.squash");
        check("t5.valid", InstValid, 0);
        BranchTaken = 0;
        tick("t5.target");
        check("t5.inst", InstOut, 9'h050);
        check("t5.ipc",  InstPC, 8'h10);
        check("t5.done", Done, 0);

        // Branch while stalled
        DecReady = 0;
        tick("t3.stall");
        BranchTaken = 1; BranchTarget = 8'h30;
        tick("t3.br");
        check("t3.valid", InstValid, 0);
        BranchTaken = 0;
        tick("t3.target");
        check("t3.ipc",  InstPC, 8'h30);
        check("t3.inst", InstOut, 9'h030);
        DecReady = 1;
        BranchTaken = 1; BranchTarget = 8'h12;
        tick("t3.br2");
        BranchTaken = 0;
        for (int k = 0; k < 10 && !Done; k++) tick("t3.run");
        check("t3.halted", Done, 1);

        // PC wrap
        Start = 1; StartAddr = 8'hFE;
        tick("t4.start");
        Start = 0;
        tick("t4.fe"); check("t4.ipc_fe", InstPC, 8'hFE);
        tick("t4.ff"); check("t4.ipc_ff", InstPC, 8'hFF);
        tick("t4.00"); check("t4.ipc_00", InstPC, 8'h00);

        // Asynchronous reset between edges
        #2 Reset = 1;
        #1;
        check("t6.valid", InstValid, 0);
        check("t6.done",  Done, 0);
        check("t6.addr",  RomAddress, 8'h00);
        model_reset();
        #1 Reset = 0;

        // Randomized traffic
        for (int i = 0; i < 256; i++)
            rom[i] = ($urandom_range(15) == 0) ? 9'h1FF : 9'($urandom_range(510));
        for (int c = 0; c < 600; c++) begin
            Start        = ($urandom_range(19) == 0);
            StartAddr    = 8'($urandom_range(255));
            DecReady     = ($urandom_range(3) != 0);
            BranchTaken  = ($urandom_range(11) == 0);
            BranchTarget = 8'($urandom_range(255));
            tick("rnd");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
